baby_exec_controller: RTL and testbench

- Run-control sequencer between the host interface (Pico-driven command bytes) and the manchester_baby core.
- Decides each cycle whether the baby's gated clock is enabled: free run, step N instructions, halt, breakpoint on RAM address, or controlled reset pulse.
- Counts executed instructions.
- Replaces direct host drive of the exec-enable and baby-reset pins at the top level.

---
 rtl/baby_exec_controller.sv | 204 ++++++++++++++++++++
 tb/tb_baby_exec_controller.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/baby_exec_controller.sv
// Run-control sequencer for the manchester_baby core: free run, step N
// instructions, halt, RAM-address breakpoint and a timed reset pulse, with
// an executed-instruction counter.
module baby_exec_controller #(
    parameter int unsigned RESET_CYCLES = 4,
    parameter int unsigned COUNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         cmd_i,
    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic               baby_clock_i,
    input  logic               stop_lamp_i,
    input  logic [4:0]         ram_addr_i,
    output logic               exec_en_o,
    output logic               baby_rst_n_o,
    output logic [2:0]         state_o,
    output logic               bp_hit_o,
    output logic [COUNT_W-1:0] instr_count_o
);

    typedef enum logic [2:0] {
        S_HALTED    = 3'd0,
        S_RUNNING   = 3'd1,
        S_STEPPING  = 3'd2,
        S_STOPPED   = 3'd3,
        S_RESETTING = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        OP_NOP       = 3'b000,
        OP_RUN       = 3'b001,
        OP_STEP      = 3'b010,
        OP_HALT      = 3'b011,
        OP_RESET     = 3'b100,
        OP_SET_BP    = 3'b101,
        OP_CLR_BP    = 3'b110,
        OP_CLR_COUNT = 3'b111
    } op_e;

    localparam logic [3:0] RST_LOAD = 4'(RESET_CYCLES - 1);

    state_e             state_q, state_d;
    logic               exec_en_q, exec_en_d;
    logic               baby_rst_n_q, baby_rst_n_d;
    logic               bclk_q;
    logic [5:0]         step_cnt_q, step_cnt_d;
    logic [3:0]         rst_cnt_q, rst_cnt_d;
    logic               bp_en_q, bp_en_d;
    logic [4:0]         bp_addr_q, bp_addr_d;
    logic               bp_hit_q, bp_hit_d;
    logic [COUNT_W-1:0] count_q, count_d;

    op_e                op;
    logic [4:0]         arg;
    logic               cmd_acc;
    logic               ib;
    logic               active;
    logic               bp_match;
    logic               step_done;
    logic               step_load;
    logic               reset_start;
    logic               lamp_block;

    assign op          = op_e'(cmd_i[7:5]);
    assign arg         = cmd_i[4:0];
    assign cmd_ready_o = (state_q != S_RESETTING);
    assign cmd_acc     = cmd_valid_i & cmd_ready_o;
    assign ib          = exec_en_q & baby_clock_i & ~bclk_q;
    assign active      = (state_q == S_RUNNING) || (state_q == S_STEPPING);
    assign bp_match    = active & bp_en_q & ib & (ram_addr_i == bp_addr_q);
    assign step_done   = (state_q == S_STEPPING) & ib & (step_cnt_q == 6'd1);
    assign lamp_block  = (state_q == S_STOPPED) & stop_lamp_i;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_HALTED;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: RESETTING timer > stop lamp > breakpoint > step done > command.
    always_comb begin
        state_d   = state_q;
        step_load = 1'b0;
        if (state_q == S_RESETTING) begin
            if (rst_cnt_q == '0) begin
                state_d = S_HALTED;
            end
        end else if (active && stop_lamp_i) begin
            state_d = S_STOPPED;
        end else if (bp_match || step_done) begin
            state_d = S_HALTED;
        end else if (cmd_acc) begin
            case (op)
                OP_RUN: begin
                    if (!lamp_block) begin
                        state_d = S_RUNNING;
                    end
                end
                OP_STEP: begin
                    if (!lamp_block) begin
                        state_d   = S_STEPPING;
                        step_load = 1'b1;
                    end
                end
                OP_HALT:  state_d = S_HALTED;
                OP_RESET: state_d = S_RESETTING;
                default:  state_d = state_q;
            endcase
        end
    end

    // Outputs decoded from the next state so they switch on the same edge as the state.
    always_comb begin
        exec_en_d    = (state_d == S_RUNNING) || (state_d == S_STEPPING);
        baby_rst_n_d = (state_d != S_RESETTING);
        reset_start  = (state_d == S_RESETTING) && (state_q != S_RESETTING);
    end

    // Registered run-control outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exec_en_q    <= 1'b0;
            baby_rst_n_q <= 1'b1;
        end else begin
            exec_en_q    <= exec_en_d;
            baby_rst_n_q <= baby_rst_n_d;
        end
    end

    // Step/reset timers, breakpoint registers and instruction counter next values.
    always_comb begin
        step_cnt_d = step_cnt_q;
        if (step_load) begin
            step_cnt_d = (arg == '0) ? 6'd32 : {1'b0, arg};
        end else if ((state_q == S_STEPPING) && ib) begin
            step_cnt_d = step_cnt_q - 6'd1;
        end

        rst_cnt_d = RST_LOAD;
        if (state_q == S_RESETTING) begin
            rst_cnt_d = (rst_cnt_q == '0) ? '0 : rst_cnt_q - 4'd1;
        end

        bp_en_d   = bp_en_q;
        bp_addr_d = bp_addr_q;
        bp_hit_d  = bp_hit_q;
        if (cmd_acc && (op == OP_SET_BP)) begin
            bp_en_d   = 1'b1;
            bp_addr_d = arg;
            bp_hit_d  = 1'b0;
        end else if (cmd_acc && (op == OP_CLR_BP)) begin
            bp_en_d  = 1'b0;
            bp_hit_d = 1'b0;
        end else if (reset_start) begin
            bp_hit_d = 1'b0;
        end
        // A hit in the same cycle as a clearing command is still reported.
        if (bp_match) begin
            bp_hit_d = 1'b1;
        end

        count_d = count_q;
        if (cmd_acc && (op == OP_CLR_COUNT)) begin
            count_d = '0;
        end else if ((state_q == S_RESETTING) && (state_d == S_HALTED)) begin
            count_d = '0;
        end else if (ib) begin
            count_d = count_q + COUNT_W'(1);
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bclk_q     <= 1'b0;
            step_cnt_q <= '0;
            rst_cnt_q  <= '0;
            bp_en_q    <= 1'b0;
            bp_addr_q  <= '0;
            bp_hit_q   <= 1'b0;
            count_q    <= '0;
        end else begin
            bclk_q     <= baby_clock_i;
            step_cnt_q <= step_cnt_d;
            rst_cnt_q  <= rst_cnt_d;
            bp_en_q    <= bp_en_d;
            bp_addr_q  <= bp_addr_d;
            bp_hit_q   <= bp_hit_d;
            count_q    <= count_d;
        end
    end

    assign exec_en_o     = exec_en_q;
    assign baby_rst_n_o  = baby_rst_n_q;
    assign state_o       = state_q;
    assign bp_hit_o      = bp_hit_q;
    assign instr_count_o = count_q;

endmodule

// File: tb/tb_baby_exec_controller.sv
// Directed bench for baby_exec_controller: a default instance plus a
// COUNT_W=4 instance driven by the same stimulus for counter wrap.
module tb_baby_exec_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  cmd_i;
    logic        cmd_valid_i;
    logic        baby_clock_i;
    logic        stop_lamp_i;
    logic [4:0]  ram_addr_i;

    logic        cmd_ready_o, exec_en_o, baby_rst_n_o, bp_hit_o;
    logic [2:0]  state_o;
    logic [15:0] instr_count_o;

    logic        s_cmd_ready_o, s_exec_en_o, s_baby_rst_n_o, s_bp_hit_o;
    logic [2:0]  s_state_o;
    logic [3:0]  s_instr_count_o;

    int tests = 0;
    int failures = 0;

    always #5 clk = ~clk;

    baby_exec_controller #(.RESET_CYCLES(4), .COUNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_i(cmd_i), .cmd_valid_i(cmd_valid_i),
        .cmd_ready_o(cmd_ready_o), .baby_clock_i(baby_clock_i),
        .stop_lamp_i(stop_lamp_i), .ram_addr_i(ram_addr_i),
        .exec_en_o(exec_en_o), .baby_rst_n_o(baby_rst_n_o), .state_o(state_o),
        .bp_hit_o(bp_hit_o), .instr_count_o(instr_count_o)
    );

    baby_exec_controller #(.RESET_CYCLES(4), .COUNT_W(4)) dut_small (
        .clk(clk), .rst_n(rst_n), .cmd_i(cmd_i), .cmd_valid_i(cmd_valid_i),
        .cmd_ready_o(s_cmd_ready_o), .baby_clock_i(baby_clock_i),
        .stop_lamp_i(stop_lamp_i), .ram_addr_i(ram_addr_i),
        .exec_en_o(s_exec_en_o), .baby_rst_n_o(s_baby_rst_n_o), .state_o(s_state_o),
        .bp_hit_o(s_bp_hit_o), .instr_count_o(s_instr_count_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [7:0] c);
        cmd_i       = c;
        cmd_valid_i = 1'b1;
        tick();
        cmd_valid_i = 1'b0;
    endtask

    task automatic pulse(input logic [4:0] a);
        ram_addr_i   = a;
        baby_clock_i = 1'b1;
        tick();
        baby_clock_i = 1'b0;
        tick();
    endtask

    initial begin
        rst_n        = 1'b0;
        cmd_i        = '0;
        cmd_valid_i  = 1'b0;
        baby_clock_i = 1'b0;
        stop_lamp_i  = 1'b0;
        ram_addr_i   = '0;
        #12;
        check("rst_exec_en", {31'd0, exec_en_o}, 32'd0);
        check("rst_baby_rst_n", {31'd0, baby_rst_n_o}, 32'd1);
        check("rst_cmd_ready", {31'd0, cmd_ready_o}, 32'd1);
        check("rst_state", {29'd0, state_o}, 32'd0);
        check("rst_bp_hit", {31'd0, bp_hit_o}, 32'd0);
        check("rst_count", {16'd0, instr_count_o}, 32'd0);
        rst_n = 1'b1;
        tick();

        // STEP 3
        send_cmd(8'h43);
        check("step3_state", {29'd0, state_o}, 32'd2);
        check("step3_exec_en", {31'd0, exec_en_o}, 32'd1);
        pulse(5'd0);
        pulse(5'd0);
        check("step3_exec_en_mid", {31'd0, exec_en_o}, 32'd1);
        check("step3_state_mid", {29'd0, state_o}, 32'd2);
        pulse(5'd0);
        check("step3_exec_en_end", {31'd0, exec_en_o}, 32'd0);
        check("step3_state_end", {29'd0, state_o}, 32'd0);
        check("step3_count", {16'd0, instr_count_o}, 32'd3);
        check("step3_small_count", {28'd0, s_instr_count_o}, 32'd3);

        // Breakpoint during RUN
        send_cmd(8'hE0);
        check("clr_count_halted", {16'd0, instr_count_o}, 32'd0);
        send_cmd(8'hA5);
        send_cmd(8'h20);
        check("run_state", {29'd0, state_o}, 32'd1);
        pulse(5'd4);
        check("bp_miss_state", {29'd0, state_o}, 32'd1);
        check("bp_miss_hit", {31'd0, bp_hit_o}, 32'd0);
        pulse(5'd5);
        check("bp_state", {29'd0, state_o}, 32'd0);
        check("bp_exec_en", {31'd0, exec_en_o}, 32'd0);
        check("bp_hit", {31'd0, bp_hit_o}, 32'd1);
        check("bp_count", {16'd0, instr_count_o}, 32'd2);
        pulse(5'd5);
        check("halted_no_count", {16'd0, instr_count_o}, 32'd2);
        send_cmd(8'hC0);
        check("clr_bp_hit", {31'd0, bp_hit_o}, 32'd0);

        // Stop lamp beats HALT, RUN ignored while lamp high, then RESET pulse
        send_cmd(8'h20);
        stop_lamp_i = 1'b1;
        send_cmd(8'h60);
        check("lamp_state", {29'd0, state_o}, 32'd3);
        check("lamp_exec_en", {31'd0, exec_en_o}, 32'd0);
        send_cmd(8'h20);
        check("lamp_run_ignored", {29'd0, state_o}, 32'd3);
        send_cmd(8'h80);
        check("reset_state", {29'd0, state_o}, 32'd4);
        check("reset_rst_n_0", {31'd0, baby_rst_n_o}, 32'd0);
        check("reset_ready_0", {31'd0, cmd_ready_o}, 32'd0);
        cmd_i       = 8'h20;
        cmd_valid_i = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("reset_rst_n_low", {31'd0, baby_rst_n_o}, 32'd0);
            check("reset_ready_low", {31'd0, cmd_ready_o}, 32'd0);
        end
        cmd_valid_i = 1'b0;
        tick();
        check("reset_rst_n_rel", {31'd0, baby_rst_n_o}, 32'd1);
        check("reset_ready_rel", {31'd0, cmd_ready_o}, 32'd1);
        check("reset_state_end", {29'd0, state_o}, 32'd0);
        check("reset_count", {16'd0, instr_count_o}, 32'd0);
        stop_lamp_i = 1'b0;

        // STEP 0 means 32 instructions; small instance wraps 15 -> 0
        send_cmd(8'h40);
        check("step32_state", {29'd0, state_o}, 32'd2);
        for (int i = 1; i <= 31; i++) begin
            pulse(5'd1);
        end
        check("step31_state", {29'd0, state_o}, 32'd2);
        check("step31_count", {16'd0, instr_count_o}, 32'd31);
        check("step31_small", {28'd0, s_instr_count_o}, 32'd15);
        pulse(5'd1);
        check("step32_state_end", {29'd0, state_o}, 32'd0);
        check("step32_count", {16'd0, instr_count_o}, 32'd32);
        check("step32_small_wrap", {28'd0, s_instr_count_o}, 32'd0);

        // CLR_COUNT coincident with an instruction boundary
        send_cmd(8'h20);
        baby_clock_i = 1'b1;
        send_cmd(8'hE0);
        baby_clock_i = 1'b0;
        tick();
        check("clr_wins", {16'd0, instr_count_o}, 32'd0);
        pulse(5'd2);
        check("count_after_clr", {16'd0, instr_count_o}, 32'd1);

        // STEP accepted in RUNNING; breakpoint on the final step
        send_cmd(8'hA7);
        send_cmd(8'h42);
        check("run_to_step", {29'd0, state_o}, 32'd2);
        pulse(5'd3);
        check("step2_mid", {29'd0, state_o}, 32'd2);
        pulse(5'd7);
        check("bp_last_state", {29'd0, state_o}, 32'd0);
        check("bp_last_hit", {31'd0, bp_hit_o}, 32'd1);
        check("bp_last_count", {16'd0, instr_count_o}, 32'd3);

        // Asynchronous reset mid-STEPPING
        send_cmd(8'h43);
        check("pre_arst_state", {29'd0, state_o}, 32'd2);
        rst_n = 1'b0;
        #2;
        check("arst_exec_en", {31'd0, exec_en_o}, 32'd0);
        check("arst_state", {29'd0, state_o}, 32'd0);
        check("arst_bp_hit", {31'd0, bp_hit_o}, 32'd0);
        check("arst_count", {16'd0, instr_count_o}, 32'd0);
        #3;
        rst_n = 1'b1;
        tick();
        send_cmd(8'h20);
        pulse(5'd0);
        pulse(5'd7);
        check("bp_disabled_state", {29'd0, state_o}, 32'd1);
        check("bp_disabled_count", {16'd0, instr_count_o}, 32'd2);
        send_cmd(8'h60);
        check("final_halt", {29'd0, state_o}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
